// File: rtl/data_memory_ctrl.sv
// Single-port data memory controller with byte/half/word loads and stores, fixed
// request-to-response latency, alignment checking and little-endian lane selection.
module data_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        We,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] Data_in,
    output logic        Ready,
    output logic        Done,
    output logic        Err,
    output logic [31:0] Data_out
);

    localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LastCnt = 4'(LATENCY - 1);

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;
    localparam logic [1:0] SzRsvd = 2'b11;

    generate
        if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
            $error("LATENCY must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;
    logic                    commit;

    // Request fields captured at accept; the transaction never looks at live inputs again.
    logic                    we_q;
    logic                    unsigned_q;
    logic [1:0]              size_q;
    logic [1:0]              lane_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;

    logic                    err_q;
    logic [31:0]             data_out_q;

    logic [31:0]             mem [Depth];

    logic [31:0]             rd_word;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [31:0]             load_val;
    logic [31:0]             wr_data;
    logic [3:0]              be;
    logic                    req_err;

    // Address bits above the word index wrap modulo the array size.
    logic                    unused_addr;
    assign unused_addr = ^Addr[31:ADDR_WIDTH+2];

    assign accept = Req && (state_q == StIdle);
    assign commit = (state_q == StBusy) && (cnt_q == LastCnt);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StBusy;
                    cnt_d   = 4'd0;
                end
            end
            StBusy: begin
                if (cnt_q == LastCnt) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= SzWord;
            lane_q     <= 2'b00;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
        end else if (accept) begin
            we_q       <= We;
            unsigned_q <= Unsigned;
            size_q     <= Size;
            lane_q     <= Addr[1:0];
            idx_q      <= Addr[ADDR_WIDTH+1:2];
            wdata_q    <= Data_in;
        end
    end

    // ------------------------------------------------------------------
    // Alignment check, lane decode and load extraction
    // ------------------------------------------------------------------
    always_comb begin
        req_err = 1'b0;
        unique case (size_q)
            SzByte:  req_err = 1'b0;
            SzHalf:  req_err = lane_q[0];
            SzWord:  req_err = (lane_q != 2'b00);
            SzRsvd:  req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        be      = 4'b0000;
        wr_data = wdata_q;
        unique case (size_q)
            SzByte: begin
                be      = 4'b0001 << lane_q;
                wr_data = {4{wdata_q[7:0]}};
            end
            SzHalf: begin
                be      = lane_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    assign rd_word = mem[idx_q];
    assign ld_byte = rd_word[{lane_q, 3'b000} +: 8];
    assign ld_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        unique case (size_q)
            SzByte:  load_val = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
            SzHalf:  load_val = {{16{~unsigned_q & ld_half[15]}}, ld_half};
            default: load_val = rd_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: not reset; a reset on the commit edge cancels the write.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (commit && !Rst && we_q && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx_q][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_q      <= 1'b0;
            data_out_q <= 32'd0;
        end else if (commit) begin
            err_q <= req_err;
            if (req_err) begin
                data_out_q <= 32'd0;
            end else if (!we_q) begin
                data_out_q <= load_val;
            end
        end
    end

    assign Ready    = (state_q == StIdle);
    assign Done     = (state_q == StResp);
    assign Err      = (state_q == StResp) && err_q;
    assign Data_out = data_out_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance at LATENCY=1, one at LATENCY=4,
// sharing clock, reset and request fields but with separate request strobes.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req4;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] din;

    logic        ready1, done1, err1;
    logic [31:0] dout1;
    logic        ready4, done4, err4;
    logic [31:0] dout4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_WIDTH(8), .LATENCY(1)) u_l1 (
        .Clk(clk), .Rst(rst), .Req(req1), .We(we), .Size(size), .Unsigned(uns),
        .Addr(addr), .Data_in(din), .Ready(ready1), .Done(done1), .Err(err1),
        .Data_out(dout1)
    );

    data_memory_ctrl #(.ADDR_WIDTH(8), .LATENCY(4)) u_l4 (
        .Clk(clk), .Rst(rst), .Req(req4), .We(we), .Size(size), .Unsigned(uns),
        .Addr(addr), .Data_in(din), .Ready(ready4), .Done(done4), .Err(err4),
        .Data_out(dout4)
    );

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    // Issue one request, scramble the inputs right after accept, and report the
    // response, the accept-to-Done latency (0 = timed out) and {Ready,Done,Err} one cycle later.
    task automatic op(input bit l4, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] dout, output logic e, output int lat,
                      output logic [2:0] after);
        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; din = d;
        if (l4) req4 = 1'b1;
        else    req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0; req4 = 1'b0;
        we = ~w; size = ~sz; uns = ~u; addr = ~a; din = ~d;
        lat = 0; e = 1'bx; dout = 'x; after = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (l4 ? done4 : done1) begin
                lat  = i;
                dout = l4 ? dout4 : dout1;
                e    = l4 ? err4 : err1;
                break;
            end
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            after = l4 ? {ready4, done4, err4} : {ready1, done1, err1};
        end
    endtask

    task automatic test_reset();
        // Request held during reset must not be accepted.
        rst = 1'b1; req1 = 1'b1; req4 = 1'b1;
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h10; din = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        req1 = 1'b0; req4 = 1'b0; rst = 1'b0;
        tests++;
        if ({ready1, done1, err1, dout1} !== {3'b100, 32'd0}) begin
            fails++;
            $display("FAIL reset_l1: got rdy/done/err=%b%b%b dout=%h, want 100 dout=00000000",
                     ready1, done1, err1, dout1);
        end
        tests++;
        if ({ready4, done4, err4, dout4} !== {3'b100, 32'd0}) begin
            fails++;
            $display("FAIL reset_l4: got rdy/done/err=%b%b%b dout=%h, want 100 dout=00000000",
                     ready4, done4, err4, dout4);
        end
        repeat (3) begin
            @(posedge clk); #1;
            tests++;
            if ({ready1, done1} !== 2'b10) begin
                fails++;
                $display("FAIL reset_priority: got rdy/done=%b%b, want 10", ready1, done1);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] d; logic e; int lat; logic [2:0] af;
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, d, e, lat, af);
        tests++;
        if (lat !== 1 || e !== 1'b0 || d !== 32'd0 || af !== 3'b100) begin
            fails++;
            $display("FAIL sw_0x10: got lat=%0d err=%b dout=%h after=%b, want 1 0 00000000 100",
                     lat, e, d, af);
        end
        op(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e, lat, af);
        tests++;
        if (lat !== 1 || e !== 1'b0 || d !== 32'h1234_5678 || af !== 3'b100) begin
            fails++;
            $display("FAIL lw_0x10: got lat=%0d err=%b dout=%h after=%b, want 1 0 12345678 100",
                     lat, e, d, af);
        end
    endtask

    task automatic test_subword();
        vec_t v [12];
        logic [31:0] d; logic e; int lat; logic [2:0] af;
        v = '{
            '{"sb_0x11",  1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 32'h1234_5678, 1'b0},
            '{"lw_0x10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_AB78, 1'b0},
            '{"lb_0x11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0,         32'hFFFF_FFAB, 1'b0},
            '{"lbu_0x11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,         32'h0000_00AB, 1'b0},
            '{"lh_0x12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'h0000_1234, 1'b0},
            '{"sw_0x14",  1'b1, 2'b10, 1'b0, 32'h14, 32'h0,         32'h0000_1234, 1'b0},
            '{"sh_0x16",  1'b1, 2'b01, 1'b0, 32'h16, 32'h5A5A_8001, 32'h0000_1234, 1'b0},
            '{"lh_0x16",  1'b0, 2'b01, 1'b0, 32'h16, 32'h0,         32'hFFFF_8001, 1'b0},
            '{"lhu_0x16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0,         32'h0000_8001, 1'b0},
            '{"lw_0x14",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0,         32'h8001_0000, 1'b0},
            '{"lb_0x17",  1'b0, 2'b00, 1'b0, 32'h17, 32'h0,         32'hFFFF_FF80, 1'b0},
            '{"lbu_0x17", 1'b0, 2'b00, 1'b1, 32'h17, 32'h0,         32'h0000_0080, 1'b0}
        };
        foreach (v[i]) begin
            op(1'b0, v[i].w, v[i].sz, v[i].u, v[i].a, v[i].d, d, e, lat, af);
            tests++;
            if (lat !== 1 || e !== v[i].exp_err || d !== v[i].exp_dout || af !== 3'b100) begin
                fails++;
                $display("FAIL %s: got lat=%0d err=%b dout=%h after=%b, want 1 %b %h 100",
                         v[i].name, lat, e, d, af, v[i].exp_err, v[i].exp_dout);
            end
        end
    endtask

    task automatic test_errors();
        vec_t v [8];
        logic [31:0] d; logic e; int lat; logic [2:0] af;
        v = '{
            '{"lw_0x12",    1'b0, 2'b10, 1'b0, 32'h12, 32'h0,         32'h0,         1'b1},
            '{"sh_0x13",    1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_FFFF, 32'h0,         1'b1},
            '{"rsvd_0x0",   1'b0, 2'b11, 1'b0, 32'h00, 32'h0,         32'h0,         1'b1},
            '{"lw_0x10_a",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_AB78, 1'b0},
            '{"lh_0x11",    1'b0, 2'b01, 1'b0, 32'h11, 32'h0,         32'h0,         1'b1},
            '{"sw_0x11",    1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFF_FFFF, 32'h0,         1'b1},
            '{"srsvd_0x10", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0,         1'b1},
            '{"lw_0x10_b",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_AB78, 1'b0}
        };
        foreach (v[i]) begin
            op(1'b0, v[i].w, v[i].sz, v[i].u, v[i].a, v[i].d, d, e, lat, af);
            tests++;
            if (lat !== 1 || e !== v[i].exp_err || d !== v[i].exp_dout || af !== 3'b100) begin
                fails++;
                $display("FAIL %s: got lat=%0d err=%b dout=%h after=%b, want 1 %b %h 100",
                         v[i].name, lat, e, d, af, v[i].exp_err, v[i].exp_dout);
            end
        end
    endtask

    task automatic test_latency4();
        logic [31:0] d; logic e; int lat; logic [2:0] af;
        bit saw_done;
        op(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, d, e, lat, af);
        tests++;
        if (lat !== 4 || e !== 1'b0 || af !== 3'b100) begin
            fails++;
            $display("FAIL l4_sw_0x20: got lat=%0d err=%b after=%b, want 4 0 100", lat, e, af);
        end
        // lw @0x20 with stray store requests pulsed while busy
        @(negedge clk);
        we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20; din = 32'h0; req4 = 1'b1;
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h20; din = 32'hBAD0_BAD0;
        tests++;
        if ({ready4, done4} !== 2'b00) begin
            fails++;
            $display("FAIL l4_edge_k: got rdy/done=%b%b, want 00", ready4, done4);
        end
        for (int i = 1; i <= 3; i++) begin
            req4 = i[0];
            @(posedge clk); #1;
            tests++;
            if ({ready4, done4} !== 2'b00) begin
                fails++;
                $display("FAIL l4_edge_k+%0d: got rdy/done=%b%b, want 00", i, ready4, done4);
            end
        end
        req4 = 1'b1;
        @(posedge clk); #1;
        req4 = 1'b0;
        tests++;
        if ({ready4, done4, err4, dout4} !== {3'b010, 32'h1122_3344}) begin
            fails++;
            $display("FAIL l4_edge_k+4: got rdy/done/err=%b%b%b dout=%h, want 010 11223344",
                     ready4, done4, err4, dout4);
        end
        @(posedge clk); #1;
        tests++;
        if ({ready4, done4} !== 2'b10) begin
            fails++;
            $display("FAIL l4_edge_k+5: got rdy/done=%b%b, want 10", ready4, done4);
        end
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done4 || !ready4) saw_done = 1'b1;
        end
        tests++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL l4_no_queue: got stray activity=%b, want 0", saw_done);
        end
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, e, lat, af);
        tests++;
        if (lat !== 4 || e !== 1'b0 || d !== 32'h1122_3344) begin
            fails++;
            $display("FAIL l4_lw_0x20: got lat=%0d err=%b dout=%h, want 4 0 11223344", lat, e, d);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic e; int lat; logic [2:0] af;
        @(negedge clk);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h20; din = 32'hDEAD_BEEF; req4 = 1'b1;
        @(posedge clk); #1;
        req4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({ready4, done4, err4, dout4} !== {3'b100, 32'd0}) begin
            fails++;
            $display("FAIL abort_reset: got rdy/done/err=%b%b%b dout=%h, want 100 00000000",
                     ready4, done4, err4, dout4);
        end
        repeat (5) @(posedge clk);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, e, lat, af);
        tests++;
        if (lat !== 4 || e !== 1'b0 || d !== 32'h1122_3344) begin
            fails++;
            $display("FAIL abort_no_write: got lat=%0d err=%b dout=%h, want 4 0 11223344",
                     lat, e, d);
        end
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h420, 32'h0, d, e, lat, af);
        tests++;
        if (lat !== 4 || e !== 1'b0 || d !== 32'h1122_3344) begin
            fails++;
            $display("FAIL alias_lw_0x420: got lat=%0d err=%b dout=%h, want 4 0 11223344",
                     lat, e, d);
        end
        op(1'b1, 1'b1, 2'b10, 1'b0, 32'h420, 32'h55AA_55AA, d, e, lat, af);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, e, lat, af);
        tests++;
        if (lat !== 4 || e !== 1'b0 || d !== 32'h55AA_55AA) begin
            fails++;
            $display("FAIL alias_sw_0x420: got lat=%0d err=%b dout=%h, want 4 0 55aa55aa",
                     lat, e, d);
        end
    endtask

    initial begin
        rst = 1'b1; req1 = 1'b0; req4 = 1'b0;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; din = 32'h0;
        test_reset();
        test_store_load();
        test_subword();
        test_errors();
        test_latency4();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d",
                 tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: word-index width; the array SHALL hold 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 1, legal 1..8: cycles from request accept to response.
REQ-003 Clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Req  input  1  request strobe; sampled only while Ready=1.
REQ-006 We  input  1  1 = store, 0 = load.
REQ-007 Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 Unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
REQ-009 Addr  input  32  byte address; bits [ADDR_WIDTH+1:2] index the word, [1:0] select the lane, higher bits ignored (modulo wrap).
REQ-010 Data_in  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 Ready  output  1  high when a request can be accepted.
REQ-012 Done  output  1  one-cycle response pulse.
REQ-013 Err  output  1  one-cycle error flag, coincident with Done.
REQ-014 Data_out  output  32  load result, valid while Done=1; otherwise holds its last value.

Function
REQ-015 Accept SHALL occur at edge k when Req=1 and Ready=1; We, Size, Unsigned, Addr and Data_in SHALL be captured at that edge, and later input changes SHALL NOT affect the transaction.
REQ-016 FSM SHALL have states IDLE, BUSY and RESP; IDLE->BUSY on accept; BUSY->RESP after LATENCY edges (counter); RESP->IDLE unconditionally at the next edge.
REQ-017 Ready SHALL be 1 only in IDLE; Done SHALL be 1 only in RESP; Done SHALL rise at edge k+LATENCY and fall at edge k+LATENCY+1, and the next accept SHALL be possible at edge k+LATENCY+1 at the earliest.
REQ-018 Byte lanes SHALL be little-endian: lane n = word bits [8n+7:8n], with n = Addr[1:0].
REQ-019 Alignment SHALL be: halfword requires Addr[0]=0; word requires Addr[1:0]=00; Size=11 SHALL always be an error.
REQ-020 An aligned store SHALL modify only the addressed lanes, committed at edge k+LATENCY; Data_out SHALL be unchanged on a store response.
REQ-021 An aligned load SHALL return the selected byte/half extended per Unsigned (the word is returned unmodified), registered into Data_out at edge k+LATENCY.
REQ-022 A load SHALL observe every store whose response completed earlier (read-after-write correct at back-to-back spacing).
REQ-023 An erroneous request SHALL follow the same timing, assert Err with Done, leave the array unmodified, and drive Data_out to 0.
REQ-024 Req asserted while Ready=0 SHALL be ignored (not queued).

Reset
REQ-025 Rst=1 at an edge SHALL force IDLE, clear the counter, and set Ready=1, Done=0, Err=0, Data_out=0 in the following cycle.
REQ-026 Rst SHALL take priority over accept and over any in-flight transaction; an in-flight store aborted before its commit edge SHALL NOT modify the array.
REQ-027 Reset SHALL NOT clear array contents.

Verification
REQ-028 LATENCY=1: sw 0x12345678 @0x10, then lw @0x10 -> Done one cycle after each accept; Data_out=0x12345678, Err=0.
REQ-029 After REQ-028: sb 0xAB @0x11, then lw @0x10 -> 0x1234AB78; lb @0x11 -> 0xFFFFFFAB; lbu @0x11 -> 0x000000AB; lh @0x12 -> 0x00001234.
REQ-030 lw @0x12, sh @0x13, Size=11 @0x0 -> each gives Done=1, Err=1, Data_out=0; a subsequent lw @0x10 still returns 0x1234AB78.
REQ-031 LATENCY=4: accept at edge k -> Ready=0 and Done=0 through edge k+3; Done=1 exactly at edge k+4; Req pulses while busy are ignored.
REQ-032 LATENCY=4: sw 0xDEADBEEF @0x20 accepted, Rst asserted at edge k+2 -> the next cycle shows Ready=1, Done=0, Data_out=0; lw @0x20 returns the prior contents; Addr 0x420 with ADDR_WIDTH=8 aliases 0x20.
